instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Boot-time writer for the instruction RAM that the fetch stage reads.
- Receives a framed little-endian byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes into 32-bit words and writes them to consecutive word addresses.
- Holds the core in reset until a checksummed load completes, then releases it with the start PC.

Parameters:
- ADDR_W, 10: instruction RAM word-address width (capacity 2**ADDR_W words).
- BASE_ADDR, 32'sh0000_0000: value driven on pc_init_o; byte address of word 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  pulse; begins a load from IDLE, DONE or ERR. Ignored while busy.
- byte_valid_i  in  1  stream byte valid.
- byte_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts byte_i this cycle.
- wr_en_o  out  1  instruction RAM write strobe, one cycle per word.
- wr_addr_o  out  ADDR_W  word address.
- wr_data_o  out  32 (word_32ut)  word to write.
- core_rst_o  out  1  reset to core/fetch; high except in DONE.
- pc_init_o  out  32 (word_st)  start PC, constant BASE_ADDR.
- busy_o  out  1  state is HDR, DATA or CSUM.
- done_o  out  1  state is DONE.
- err_o  out  1  state is ERR.

Behaviour:
- Handshake: a byte is accepted on any cycle with byte_valid_i && byte_ready_o.
  - byte_ready_o = 1 only in HDR, DATA and CSUM.
  - Valid bytes arriving in other states are neither consumed nor buffered.
- Frame format:
  - 4-byte word count N, LSB first.
  - N*4 payload bytes; each word LSB first (byte k goes to bits 8k+7:8k).
  - 1 checksum byte = XOR of all payload bytes.
- Reset, and reset mid-operation:
  - State goes to IDLE.
  - core_rst_o=1; wr_en_o, byte_ready_o, busy_o, done_o, err_o = 0; wr_addr_o and wr_data_o = 0.
  - Word index, byte counter and checksum accumulator cleared.
  - Words already written stay in RAM; there is no rollback.
- IDLE: start_i -> HDR.
- HDR:
  - Accept 4 bytes into count.
  - On the 4th accepted byte: if count==0 or count>2**ADDR_W -> ERR, else -> DATA.
- DATA:
  - On each 4th accepted byte, wr_en_o is asserted the following cycle for exactly one cycle.
  - wr_addr_o = current word index (starting at 0); wr_data_o = assembled word.
  - The word index increments after the write.
  - Bytes may continue to be accepted in the cycle the write strobe is high (zero-bubble streaming).
  - Every payload byte is XORed into the accumulator.
  - After word N-1 completes -> CSUM.
- CSUM:
  - Accept 1 byte.
  - Equal to the accumulator -> DONE; otherwise -> ERR.
  - The write strobe for word N-1 may coincide with the first CSUM cycle.
- DONE:
  - core_rst_o=0 in every cycle the registered state is DONE; done_o=1.
  - start_i -> HDR with core_rst_o=1 on the next cycle; word index and accumulator cleared.
- ERR:
  - err_o=1; core_rst_o stays 1.
  - start_i -> HDR with the same clearing as from DONE.
- All outputs are registered or decoded from registered state only; no combinational path from byte_valid_i to any output.
- Boundaries:
  - count == 2**ADDR_W is valid; the last write is at address 2**ADDR_W-1, and the index never wraps during a load.
  - start_i together with rst_i: reset wins.
  - start_i while busy: ignored, load continues.
  - Long gaps in byte_valid_i: no timeout; the loader waits indefinitely.

Decomposition:
- Shared package (definitions_pkg):
  - loader_state_e enum {IDLE, HDR, DATA, CSUM, DONE, ERR}.
  - byte_t typedef (logic [7:0]).
  - LOADER_HDR_BYTES = 4 and LOADER_WORD_BYTES = 4.
  - Reuse word_32ut and word_st.
- One sub-module, byte_packer:
  - 2-bit byte counter and little-endian shift/assemble register.
  - Emits a one-cycle word_valid with the assembled word.
  - Inputs: clear, accept.
- The top owns the FSM, count register, word index and XOR accumulator.

Test Plan:
- Nominal load:
  - Stimulus: start_i, then bytes 02 00 00 00, 13 00 00 00, 93 00 A0 00, checksum 20.
  - Response: write addr0=0x00000013, then addr1=0x00A00093, each a single-cycle wr_en_o; done_o=1; core_rst_o=0; pc_init_o=BASE_ADDR.
- Bad checksum:
  - Stimulus: same frame with checksum 21.
  - Response: both writes still occur; err_o=1, core_rst_o stays 1; a new start_i plus the correct frame reaches DONE.
- Header limits:
  - count 0 -> ERR right after the 4th header byte, no writes.
  - count 2**ADDR_W+1 (0x401 for ADDR_W=10) -> ERR.
  - count 0x400 with checksum 00 over all-zero words -> 1024 writes, last at addr 0x3FF, DONE.
- Backpressure and gaps:
  - Stimulus: nominal frame with byte_valid_i toggled pseudo-randomly; also bytes driven while in IDLE.
  - Response: identical writes and DONE; bytes driven in IDLE are not accepted (byte_ready_o=0).
- Mid-load reset:
  - Stimulus: assert rst_i after 5 payload bytes.
  - Response: next cycle IDLE, core_rst_o=1, no further wr_en_o, word 0 not rewritten; a subsequent full load succeeds from addr 0.
- Reload:
  - Stimulus: start_i while in DONE.
  - Response: core_rst_o=1 and busy_o=1 next cycle; a new 1-word frame writes addr 0; done_o returns.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared types and constants for the instruction-RAM boot loader.
// Both the top and the byte packer take their word and byte types from here.
package definitions_pkg;

    typedef logic [31:0]        word_32ut;
    typedef logic signed [31:0] word_st;
    typedef logic [7:0]         byte_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam int LOADER_HDR_BYTES  = 4;
    localparam int LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake plus instruction-RAM write port of the boot loader.
// slave = loader side, master = stream source / RAM side.
interface instr_loader_if
    import definitions_pkg::*;
#(
    parameter int ADDR_W = 10
);

    logic              byte_valid_i;
    byte_t             byte_i;
    logic              byte_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    word_32ut          wr_data_o;

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        input  wr_en_o,
        input  wr_addr_o,
        input  wr_data_o
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word assembler: four accepted bytes produce one
// registered word with a single-cycle valid on the following cycle.
module byte_packer
    import definitions_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clear_i,
    input  logic     accept_i,
    input  byte_t    byte_i,
    output logic     last_o,
    output logic     word_valid_o,
    output word_32ut word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        word_valid_q, word_valid_d;
    word_32ut    word_q, word_d;

    // Bytes enter at the top so the first byte ends up in bits 7:0.
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        last_o       = accept_i && (cnt_q == 2'(LOADER_WORD_BYTES - 1));
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
            if (last_o) begin
                word_valid_d = 1'b1;
                word_d       = {byte_i, shift_q};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction RAM writer: parses a count/payload/checksum byte frame,
// writes consecutive words, and holds the core in reset until a good load.
module instr_loader
    import definitions_pkg::*;
#(
    parameter int     ADDR_W    = 10,
    parameter word_st BASE_ADDR = 32'sh0000_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    instr_loader_if.slave  bus,
    output logic           core_rst_o,
    output word_st         pc_init_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    loader_state_e     state_q, state_d;
    word_32ut          count_q, count_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    byte_t             acc_q, acc_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              byte_ready;
    logic              accept;
    logic              load_start;
    logic              word_last;
    logic              word_valid;
    word_32ut          word;
    word_32ut          hdr_word;
    logic [ADDR_W:0]   last_idx;

    assign accept     = bus.byte_valid_i && byte_ready;
    assign load_start = start_i && !busy_o;
    assign hdr_word   = {bus.byte_i, count_q[31:8]};
    assign last_idx   = count_q[ADDR_W:0] - (ADDR_W + 1)'(1);

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (load_start),
        .accept_i     (accept && (state_q == DATA)),
        .byte_i       (bus.byte_i),
        .last_o       (word_last),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            hdr_cnt_q <= '0;
            widx_q    <= '0;
            acc_q     <= '0;
            wr_addr_q <= '0;
        end else begin
            count_q   <= count_d;
            hdr_cnt_q <= hdr_cnt_d;
            widx_q    <= widx_d;
            acc_q     <= acc_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hdr_cnt_d = hdr_cnt_q;
        widx_d    = widx_q;
        acc_d     = acc_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d   = HDR;
                    count_d   = '0;
                    hdr_cnt_d = '0;
                    widx_d    = '0;
                    acc_d     = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    count_d   = hdr_word;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    // Full 32-bit count is range-checked so oversize frames never wrap the index.
                    if (hdr_cnt_q == 2'(LOADER_HDR_BYTES - 1)) begin
                        if ((hdr_word == '0) || ({1'b0, hdr_word} > MAX_WORDS)) state_d = ERR;
                        else                                                     state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    acc_d = acc_q ^ bus.byte_i;
                    if (word_last) begin
                        wr_addr_d = widx_q[ADDR_W-1:0];
                        widx_d    = widx_q + (ADDR_W + 1)'(1);
                        if (widx_q == last_idx) state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) state_d = (bus.byte_i == acc_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        core_rst_o = 1'b1;
        case (state_q)
            HDR, DATA, CSUM: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
            DONE: begin
                done_o     = 1'b1;
                core_rst_o = 1'b0;
            end
            ERR:     err_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.wr_en_o      = word_valid;
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = word;
    assign pc_init_o        = BASE_ADDR;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader: frames are built from word
// lists, and expected writes/outcome come from the frame rules directly.
module tb_instr_loader;
    import definitions_pkg::*;

    localparam int     ADDR_W = 10;
    localparam word_st BASE   = 32'sh0000_0800;

    logic   clk;
    logic   rst;
    logic   start;
    logic   core_rst;
    word_st pc_init;
    logic   busy, done, err;

    instr_loader_if #(.ADDR_W(ADDR_W)) lif ();

    instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .bus        (lif.slave),
        .core_rst_o (core_rst),
        .pc_init_o  (pc_init),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed RAM writes, one entry per strobe cycle.
    logic [ADDR_W-1:0] wa_q[$];
    word_32ut          wd_q[$];
    always @(negedge clk) begin
        if (lif.wr_en_o === 1'b1) begin
            wa_q.push_back(lif.wr_addr_o);
            wd_q.push_back(lif.wr_data_o);
        end
    end

    word_32ut words[$];
    byte_t    tx_q[$];

    function automatic byte_t model_csum();
        byte_t x;
        x = '0;
        foreach (words[i]) x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        return x;
    endfunction

    // Outcome of a frame by the loader's rules: 0 = DONE, 1 = ERR.
    function automatic int model_outcome(input word_32ut cnt, input byte_t flip);
        if (cnt == 0 || cnt > (32'd1 << ADDR_W)) return 1;
        return (flip == 8'h00) ? 0 : 1;
    endfunction

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(word_32ut'($urandom));
    endtask

    task automatic build_frame(input word_32ut cnt, input bit with_payload, input byte_t flip);
        tx_q.delete();
        for (int b = 0; b < 4; b++) tx_q.push_back(cnt[8*b +: 8]);
        if (with_payload) begin
            foreach (words[i]) for (int b = 0; b < 4; b++) tx_q.push_back(words[i][8*b +: 8]);
            tx_q.push_back(model_csum() ^ flip);
        end
    endtask

    task automatic send_bytes(input int lo, input int hi, input int gap_pct);
        for (int i = lo; i < hi; i++) begin
            int waited;
            bit taken;
            waited = 0;
            taken  = 1'b0;
            while (!taken) begin
                lif.byte_valid_i = ($urandom_range(99) >= gap_pct);
                lif.byte_i       = lif.byte_valid_i ? tx_q[i] : byte_t'($urandom);
                taken            = lif.byte_valid_i && lif.byte_ready_o;
                @(posedge clk); #1;
                waited++;
                if (!taken && waited > 200) begin
                    checks++; errors++;
                    $display("FAIL byte_accept_timeout idx=%0d ready=%b want ready=1", i, lif.byte_ready_o);
                    lif.byte_valid_i = 1'b0;
                    return;
                end
            end
        end
        lif.byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({core_rst, busy, done, err, lif.byte_ready_o, lif.wr_en_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got core_rst/busy/done/err/ready/wr_en=%b want 100000",
                     {core_rst, busy, done, err, lif.byte_ready_o, lif.wr_en_o});
        end
        checks++;
        if (lif.wr_addr_o !== '0 || lif.wr_data_o !== '0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h want 0/0", lif.wr_addr_o, lif.wr_data_o);
        end
        checks++;
        if (pc_init !== BASE) begin
            errors++;
            $display("FAIL pc_init got=%h want=%h", pc_init, BASE);
        end
    endtask

    task automatic test_idle_bytes();
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            lif.byte_valid_i = 1'b1;
            lif.byte_i       = byte_t'($urandom);
            checks++;
            if (lif.byte_ready_o !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready cyc=%0d got ready=%b busy=%b want 0/0", i, lif.byte_ready_o, busy);
            end
            @(posedge clk); #1;
        end
        lif.byte_valid_i = 1'b0;
        checks++;
        if (wa_q.size() != 0) begin
            errors++;
            $display("FAIL idle_writes got=%0d want=0", wa_q.size());
        end
    endtask

    task automatic test_nominal();
        clear_mon();
        words = '{32'h0000_0013, 32'h00A0_0093};
        tx_q  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'hA0, 8'h00, 8'h20};
        pulse_start();
        send_bytes(0, tx_q.size(), 0);
        checks++;
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL nominal_wr_count got=%0d want=2", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < words.size(); i++) begin
            checks++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== words[i]) begin
                errors++;
                $display("FAIL nominal_wr[%0d] got addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], ADDR_W'(i), words[i]);
            end
        end
        checks++;
        if ({done, err, busy, core_rst} !== 4'b1000 || pc_init !== BASE) begin
            errors++;
            $display("FAIL nominal_done got done/err/busy/core_rst=%b pc=%h want 1000 pc=%h",
                     {done, err, busy, core_rst}, pc_init, BASE);
        end
    endtask

    task automatic test_reload();
        clear_mon();
        pulse_start();
        checks++;
        if ({core_rst, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL reload_enter got core_rst/busy/done=%b want 110", {core_rst, busy, done});
        end
        fill_words(1);
        build_frame(32'd1, 1'b1, 8'h00);
        send_bytes(0, tx_q.size(), 0);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== words[0] || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_load got writes=%0d done=%b want 1 write of %h at 0 and done=1",
                     wa_q.size(), done, words[0]);
        end
    endtask

    task automatic test_bad_csum();
        clear_mon();
        words = '{32'h0000_0013, 32'h00A0_0093};
        build_frame(32'd2, 1'b1, 8'h01);
        pulse_start();
        send_bytes(0, tx_q.size(), 0);
        checks++;
        if (wa_q.size() != 2 || wd_q[0] !== words[0] || wd_q[1] !== words[1]) begin
            errors++;
            $display("FAIL badcsum_writes got count=%0d want 2 matching writes", wa_q.size());
        end
        checks++;
        if ({err, done, core_rst} !== 3'b101) begin
            errors++;
            $display("FAIL badcsum_state got err/done/core_rst=%b want 101", {err, done, core_rst});
        end
        clear_mon();
        build_frame(32'd2, 1'b1, 8'h00);
        pulse_start();
        send_bytes(0, tx_q.size(), 0);
        checks++;
        if ({done, err, core_rst} !== 3'b100 || wa_q.size() != 2) begin
            errors++;
            $display("FAIL badcsum_recover got done/err/core_rst=%b writes=%0d want 100 and 2",
                     {done, err, core_rst}, wa_q.size());
        end
    endtask

    task automatic test_hdr_limits();
        word_32ut bad[2];
        bad[0] = 32'd0;
        bad[1] = (32'd1 << ADDR_W) + 32'd1;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            build_frame(bad[k], 1'b0, 8'h00);
            pulse_start();
            send_bytes(0, 4, 0);
            checks++;
            if ((model_outcome(bad[k], 8'h00) == 1) !== (err === 1'b1) || busy !== 1'b0
                || lif.byte_ready_o !== 1'b0 || core_rst !== 1'b1 || wa_q.size() != 0) begin
                errors++;
                $display("FAIL hdr_limit cnt=%h got err=%b busy=%b ready=%b writes=%0d want err=1 busy=0 ready=0 writes=0",
                         bad[k], err, busy, lif.byte_ready_o, wa_q.size());
            end
        end
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 4; it++) begin
            int     n;
            byte_t  flip;
            n    = $urandom_range(8, 1);
            flip = (it == 2) ? byte_t'($urandom_range(255, 1)) : 8'h00;
            clear_mon();
            fill_words(n);
            build_frame(word_32ut'(n), 1'b1, flip);
            pulse_start();
            send_bytes(0, tx_q.size(), 45);
            checks++;
            if (wa_q.size() != n) begin
                errors++;
                $display("FAIL gaps_wr_count it=%0d got=%0d want=%0d", it, wa_q.size(), n);
            end
            for (int i = 0; i < wa_q.size() && i < n; i++) begin
                checks++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== words[i]) begin
                    errors++;
                    $display("FAIL gaps_wr[%0d] it=%0d got addr=%h data=%h want addr=%h data=%h",
                             i, it, wa_q[i], wd_q[i], ADDR_W'(i), words[i]);
                end
            end
            checks++;
            if (model_outcome(word_32ut'(n), flip) == 0 ? (done !== 1'b1 || core_rst !== 1'b0)
                                                        : (err !== 1'b1 || core_rst !== 1'b1)) begin
                errors++;
                $display("FAIL gaps_outcome it=%0d got done=%b err=%b core_rst=%b want outcome=%0d",
                         it, done, err, core_rst, model_outcome(word_32ut'(n), flip));
            end
        end
    endtask

    task automatic test_start_busy();
        clear_mon();
        fill_words(3);
        build_frame(32'd3, 1'b1, 8'h00);
        pulse_start();
        send_bytes(0, 6, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_state got busy=%b want 1", busy);
        end
        send_bytes(6, tx_q.size(), 0);
        checks++;
        if (done !== 1'b1 || wa_q.size() != 3 || wd_q[2] !== words[2] || wa_q[2] !== ADDR_W'(2)) begin
            errors++;
            $display("FAIL start_busy_load got done=%b writes=%0d want done=1 writes=3", done, wa_q.size());
        end
    endtask

    task automatic test_midload_reset();
        clear_mon();
        fill_words(2);
        build_frame(32'd2, 1'b1, 8'h00);
        pulse_start();
        send_bytes(0, 9, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({core_rst, busy, done, err, lif.byte_ready_o, lif.wr_en_o} !== 6'b100000
            || lif.wr_addr_o !== '0 || lif.wr_data_o !== '0) begin
            errors++;
            $display("FAIL midrst_state got flags=%b addr=%h data=%h want 100000 0 0",
                     {core_rst, busy, done, err, lif.byte_ready_o, lif.wr_en_o}, lif.wr_addr_o, lif.wr_data_o);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== words[0]) begin
            errors++;
            $display("FAIL midrst_writes got=%0d want exactly word0=%h at 0", wa_q.size(), words[0]);
        end
        clear_mon();
        pulse_start();
        send_bytes(0, tx_q.size(), 20);
        checks++;
        if (done !== 1'b1 || wa_q.size() != 2 || wa_q[0] !== '0 || wd_q[1] !== words[1]) begin
            errors++;
            $display("FAIL midrst_reload got done=%b writes=%0d want done=1 writes=2 from 0", done, wa_q.size());
        end
    endtask

    task automatic test_max_count();
        int n;
        n = 1 << ADDR_W;
        clear_mon();
        fill_words(n);
        build_frame(word_32ut'(n), 1'b1, 8'h00);
        pulse_start();
        send_bytes(0, tx_q.size(), 0);
        checks++;
        if (wa_q.size() != n) begin
            errors++;
            $display("FAIL max_wr_count got=%0d want=%0d", wa_q.size(), n);
        end
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            checks++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== words[i]) begin
                errors++;
                $display("FAIL max_wr[%0d] got addr=%h data=%h want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], ADDR_W'(i), words[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL max_done got done=%b core_rst=%b want 1/0", done, core_rst);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog sim_time=%0t want finish before 5ms", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        lif.byte_valid_i = 1'b0;
        lif.byte_i       = '0;
        @(posedge clk); #1;
        test_reset();
        test_idle_bytes();
        test_nominal();
        test_reload();
        test_bad_csum();
        test_hdr_limits();
        test_gaps();
        test_start_busy();
        test_midload_reset();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
